nec_ir_transmit: RTL and testbench

NEC-protocol infrared frame transmitter, the sending side of the IR link whose receiver decodes remote-control keys into 32-bit words for the game logic. It accepts a 16-bit custom code and an 8-bit key code and serialises a complete NEC frame: 9 ms leader, 32 pulse-distance bits, and stop mark. It can also send an NEC repeat frame. It drives an IR LED with a modulated carrier, and drives an active-low demodulated envelope that can be looped straight into the receiver's IRDA_RXD input for self-test.

---
 rtl/nec_ir_transmit.sv | 164 ++++++++++++++++
 tb/tb_nec_ir_transmit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_transmit.sv
// NEC infrared frame transmitter: leader, 32 pulse-distance bits, stop mark,
// and a repeat frame, with a modulated LED drive and an active-low envelope.
//
// Ports:
//   master_clk  : system clock, the only clock
//   reset       : synchronous active-high reset
//   start       : request a data frame, sampled while idle
//   repeat_req  : request a repeat frame, sampled while idle (start wins)
//   custom_code : 16-bit custom field, latched on accept
//   key_code    : 8-bit key field, latched on accept
//   busy        : high from the cycle after accept until the gap ends
//   done        : one-cycle pulse when a frame and its gap complete
//   ir_carrier  : carrier during marks, 0 otherwise
//   irda_txd    : 0 during marks, 1 during spaces and idle
module nec_ir_transmit #(
   parameter int UNIT_CYCLES  = 28000,
   parameter int CARRIER_HALF = 658,
   parameter int GAP_UNITS    = 70
) (
   input  logic        master_clk,
   input  logic        reset,
   input  logic        start,
   input  logic        repeat_req,
   input  logic [15:0] custom_code,
   input  logic [7:0]  key_code,
   output logic        busy,
   output logic        done,
   output logic        ir_carrier,
   output logic        irda_txd
);

   localparam int CW = $clog2(UNIT_CYCLES + 1);
   localparam int KW = $clog2(CARRIER_HALF + 1);
   localparam int MAXU = (GAP_UNITS > 16) ? GAP_UNITS : 16;
   localparam int UW = $clog2(MAXU + 1);

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK,
      GAP
   } stateT;

   stateT         state;
   stateT         nextState;
   logic [CW-1:0] cycCnt;
   logic [UW-1:0] unitCnt;
   logic [UW-1:0] nextDur;
   logic [KW-1:0] carCnt;
   logic [4:0]    bitIdx;
   logic [31:0]   shiftWord;
   logic          isRepeat;
   logic          unitTick;
   logic          inMark;
   logic          nextMark;

   assign unitTick = (cycCnt == CW'(UNIT_CYCLES - 1));

   assign inMark = (state == LEAD_MARK) ||
                   (state == BIT_MARK)  ||
                   (state == STOP_MARK);

   // Successor of the current state, used only on its last unit tick.
   always_comb begin
      nextState = IDLE;
      unique case (state)
         IDLE:       nextState = LEAD_MARK;
         LEAD_MARK:  nextState = LEAD_SPACE;
         LEAD_SPACE: nextState = isRepeat ? STOP_MARK : BIT_MARK;
         BIT_MARK:   nextState = BIT_SPACE;
         BIT_SPACE:  nextState = (bitIdx == 5'd31) ? STOP_MARK : BIT_MARK;
         STOP_MARK:  nextState = GAP;
         GAP:        nextState = IDLE;
         default:    nextState = IDLE;
      endcase
   end

   // Duration in units of the state being entered.  The bit space length
   // comes from the bit whose mark is just ending.
   always_comb begin
      nextDur = '0;
      unique case (nextState)
         IDLE:       nextDur = '0;
         LEAD_MARK:  nextDur = UW'(16);
         LEAD_SPACE: nextDur = isRepeat ? UW'(4) : UW'(8);
         BIT_MARK:   nextDur = UW'(1);
         BIT_SPACE:  nextDur = shiftWord[bitIdx] ? UW'(3) : UW'(1);
         STOP_MARK:  nextDur = UW'(1);
         GAP:        nextDur = UW'(GAP_UNITS);
         default:    nextDur = '0;
      endcase
   end

   assign nextMark = (nextState == LEAD_MARK) ||
                     (nextState == BIT_MARK)  ||
                     (nextState == STOP_MARK);

   always_ff @(posedge master_clk) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         ir_carrier <= 1'b0;
         irda_txd   <= 1'b1;
         cycCnt     <= '0;
         unitCnt    <= '0;
         carCnt     <= '0;
         bitIdx     <= '0;
         shiftWord  <= '0;
         isRepeat   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start || repeat_req) begin
               shiftWord  <= {~key_code, key_code, custom_code};
               isRepeat   <= ~start;
               state      <= LEAD_MARK;
               unitCnt    <= UW'(16);
               cycCnt     <= '0;
               carCnt     <= '0;
               bitIdx     <= '0;
               busy       <= 1'b1;
               irda_txd   <= 1'b0;
               ir_carrier <= 1'b1;
            end
         end else begin
            cycCnt <= unitTick ? '0 : cycCnt + CW'(1);
            // Carrier phase toggles every CARRIER_HALF cycles of a mark.
            if (inMark) begin
               if (carCnt == KW'(CARRIER_HALF - 1)) begin
                  carCnt     <= '0;
                  ir_carrier <= ~ir_carrier;
               end else begin
                  carCnt <= carCnt + KW'(1);
               end
            end
            if (unitTick) begin
               if (unitCnt == UW'(1)) begin
                  // State change: outputs are set for the new state's
                  // first cycle, so there is no dead cycle in between.
                  state      <= nextState;
                  unitCnt    <= nextDur;
                  carCnt     <= '0;
                  irda_txd   <= ~nextMark;
                  ir_carrier <= nextMark;
                  if (state == BIT_SPACE && nextState == BIT_MARK)
                     bitIdx <= bitIdx + 5'd1;
                  if (nextState == IDLE) begin
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     bitIdx <= '0;
                  end
               end else begin
                  unitCnt <= unitCnt - UW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_nec_ir_transmit.sv
// Directed bench for nec_ir_transmit with a segment-length scoreboard.
// Expected envelope runs are queued at launch and compared as frames end.
module tb_nec_ir_transmit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        rpt;
   logic [15:0] custom;
   logic [7:0]  key;
   logic        busy;
   logic        done;
   logic        ir_carrier;
   logic        irda_txd;

   int nVec = 0;
   int nErr = 0;

   typedef struct {
      int          nseg;
      int          busyLen;
      logic        rep;
      logic [31:0] word;
   } frame_t;

   int     expQ[$];
   frame_t frameQ[$];
   int     segQ[$];
   int     busyLenQ[$];

   int   doneCnt = 0;
   int   expDone = 0;
   int   carBad = 0;
   logic inFrame = 1'b0;

   nec_ir_transmit #(
      .UNIT_CYCLES(10),
      .CARRIER_HALF(2),
      .GAP_UNITS(4)
   ) dut (
      .master_clk(clk),
      .reset(reset),
      .start(start),
      .repeat_req(rpt),
      .custom_code(custom),
      .key_code(key),
      .busy(busy),
      .done(done),
      .ir_carrier(ir_carrier),
      .irda_txd(irda_txd)
   );

   always #5 clk = ~clk;

   // Monitor: envelope run lengths while busy (+high / -low), busy length,
   // done pulses, and the carrier pattern.
   initial begin
      logic lvl;
      int   len;
      int   flen;
      int   markPos;
      lvl = 1'b1;
      len = 0;
      flen = 0;
      markPos = 0;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            if (!inFrame) begin
               inFrame = 1'b1;
               lvl = irda_txd;
               len = 1;
               flen = 1;
            end else begin
               flen++;
               if (irda_txd === lvl) len++;
               else begin
                  segQ.push_back(lvl ? len : -len);
                  lvl = irda_txd;
                  len = 1;
               end
            end
         end else if (inFrame) begin
            segQ.push_back(lvl ? len : -len);
            busyLenQ.push_back(flen);
            inFrame = 1'b0;
         end
         if (done === 1'b1) doneCnt++;
         if (irda_txd === 1'b0) begin
            if (ir_carrier !== (((markPos / 2) % 2) == 0)) carBad++;
            markPos++;
         end else begin
            if (ir_carrier !== 1'b0) carBad++;
            markPos = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pushExp(input logic rep, input logic [15:0] c,
                          input logic [7:0] k);
      frame_t f;
      int     total;
      logic [31:0] w;
      w = {~k, k, c};
      f.rep = rep;
      f.word = w;
      expQ.push_back(-160);
      total = 160;
      if (rep) begin
         expQ.push_back(40);
         total += 40;
         f.nseg = 4;
      end else begin
         expQ.push_back(80);
         total += 80;
         for (int i = 0; i < 32; i++) begin
            expQ.push_back(-10);
            expQ.push_back(w[i] ? 30 : 10);
            total += w[i] ? 40 : 20;
         end
         f.nseg = 68;
      end
      expQ.push_back(-10);
      expQ.push_back(40);
      total += 50;
      f.busyLen = total;
      frameQ.push_back(f);
   endtask

   task automatic launch(input logic s, input logic r, input logic [15:0] c,
                         input logic [7:0] k, input logic push);
      if (push) begin
         pushExp(!s, c, k);
         expDone++;
      end
      start = s;
      rpt = r;
      custom = c;
      key = k;
      @(negedge clk);
      start = 1'b0;
      rpt = 1'b0;
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done, 1);
   endtask

   task automatic afterDone();
      @(negedge clk);
      chk("done_width", done, 0);
      chk("busy_after", busy, 0);
   endtask

   task automatic checkFrame(input string name);
      frame_t      f;
      int          o[68];
      int          e;
      int          bl;
      logic [31:0] dw;
      if (frameQ.size() == 0) begin
         chk({name, "_noexp"}, 0, 1);
         return;
      end
      f = frameQ.pop_front();
      for (int i = 0; i < f.nseg; i++) begin
         e = expQ.pop_front();
         o[i] = (segQ.size() > 0) ? segQ.pop_front() : 0;
         chk($sformatf("%s_seg%0d", name, i), o[i], e);
      end
      bl = (busyLenQ.size() > 0) ? busyLenQ.pop_front() : -1;
      chk({name, "_busy_len"}, bl, f.busyLen);
      if (!f.rep) begin
         dw = '0;
         for (int i = 0; i < 32; i++) dw[i] = (o[3 + 2 * i] > 20);
         chk({name, "_word"}, dw, f.word);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b1;
      rpt = 1'b0;
      custom = 16'h0000;
      key = 8'h00;

      // Reset with start held high: stays idle.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_txd", irda_txd, 1);
         chk("rst_carrier", ir_carrier, 0);
      end
      reset = 1'b0;
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_busy", busy, 0);

      // All-zero data frame.
      launch(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
      chk("accept_busy", busy, 1);
      chk("accept_txd", irda_txd, 0);
      waitDone();
      afterDone();
      checkFrame("zero");

      // Bit order check.
      launch(1'b1, 1'b0, 16'h6B86, 8'h35, 1'b1);
      waitDone();
      afterDone();
      checkFrame("order");
      frameQ.push_back('{nseg: 0, busyLen: 0, rep: 1'b0, word: 32'h0});
      void'(frameQ.pop_back());

      // Repeat frame.
      launch(1'b0, 1'b1, 16'hFFFF, 8'hFF, 1'b1);
      waitDone();
      afterDone();
      checkFrame("repeat");

      // start and repeat together: data frame wins.
      launch(1'b1, 1'b1, 16'h1234, 8'hA5, 1'b1);
      waitDone();
      afterDone();
      checkFrame("both");

      // start pulsed mid-frame is ignored and not queued.
      launch(1'b1, 1'b0, 16'h00FF, 8'h12, 1'b1);
      repeat (300) @(negedge clk);
      chk("mid_busy", busy, 1);
      start = 1'b1;
      custom = 16'hFFFF;
      key = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      waitDone();
      afterDone();
      checkFrame("mid");
      repeat (300) @(negedge clk);
      chk("no_queue_busy", busy, 0);
      chk("no_queue_frames", busyLenQ.size(), 0);

      // Back-to-back: request on the done cycle.
      launch(1'b1, 1'b0, 16'hBEEF, 8'h5A, 1'b1);
      waitDone();
      pushExp(1'b0, 16'h0F0F, 8'hC3);
      expDone++;
      start = 1'b1;
      custom = 16'h0F0F;
      key = 8'hC3;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", busy, 1);
      chk("b2b_txd", irda_txd, 0);
      chk("b2b_done", done, 0);
      checkFrame("b2b_a");
      waitDone();
      afterDone();
      checkFrame("b2b_b");
      chk("done_count", doneCnt, expDone);

      // Reset during the bit-5 space.
      launch(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
      repeat (355) @(negedge clk);
      chk("bit5_space_txd", irda_txd, 1);
      chk("bit5_space_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_txd", irda_txd, 1);
      chk("mrst_carrier", ir_carrier, 0);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      chk("mrst_no_done", doneCnt, expDone);
      chk("mrst_idle", busy, 0);
      segQ.delete();
      busyLenQ.delete();

      chk("carrier_errors", carBad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
